panel_scroll_bank: RTL and testbench

Parametrised bank of ROWS circular row registers, each WIDTH bits, driving the LED panel rows. It is the successor to the fixed 5x16 register bank with hard-wired patterns: patterns are loaded from a port, and rotation runs left or right at a programmable step rate. It tracks the scroll position and flags each full revolution. It sits between the pattern/message source and the column/row driver of the electronic panel.

---
 rtl/panel_scroll_bank.sv | 61 ++++++
 tb/tb_panel_scroll_bank.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/panel_scroll_bank.sv
// panel_scroll_bank: bank of circular row registers with loadable patterns and rate-divided left/right scrolling
module panel_scroll_bank #(
  parameter int ROWS = 5,
  parameter int WIDTH = 16,
  parameter int DIV_W = 8,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [ROWS*WIDTH-1:0] pattern_in,
  input  logic [DIV_W-1:0]      div,
  output logic [ROWS-1:0]       row_bits,
  output logic [ROWS*WIDTH-1:0] rows_out,
  output logic [POS_W-1:0]      pos,
  output logic                  step_o,
  output logic                  wrap_o
);
  logic [WIDTH-1:0] rows [ROWS];
  logic [DIV_W-1:0] presc;
  logic [POS_W-1:0] pos_nxt;
  logic             load, rotating, left, step;
  always_comb begin
    load     = mode == 2'b01;
    rotating = mode[1];
    left     = ~mode[0];
    step     = rotating && presc >= div;
    pos_nxt  = left ? (pos == POS_W'(WIDTH-1) ? '0 : pos + POS_W'(1))
                    : (pos == '0 ? POS_W'(WIDTH-1) : pos - POS_W'(1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) rows[r] <= '0;
      presc  <= '0;
      pos    <= '0;
      step_o <= 1'b0;
      wrap_o <= 1'b0;
    end else begin
      step_o <= step;
      wrap_o <= step && pos_nxt == '0;
      if (load) begin
        for (int r = 0; r < ROWS; r++) rows[r] <= pattern_in[r*WIDTH +: WIDTH];
        pos   <= '0;
        presc <= '0;
      end else if (rotating) begin
        presc <= step ? '0 : presc + DIV_W'(1);
        if (step) begin
          for (int r = 0; r < ROWS; r++)
            rows[r] <= left ? {rows[r][WIDTH-2:0], rows[r][WIDTH-1]} : {rows[r][0], rows[r][WIDTH-1:1]};
          pos <= pos_nxt;
        end
      end else begin
        presc <= '0;
      end
    end
  end
  for (genvar g = 0; g < ROWS; g++) begin : g_out
    assign rows_out[g*WIDTH +: WIDTH] = rows[g];
    assign row_bits[g] = rows[g][WIDTH-1];
  end
endmodule

// File: tb/tb_panel_scroll_bank.sv
// tb_panel_scroll_bank: directed checks of load, scroll, hold, wrap and reset priority
module tb_panel_scroll_bank;
  logic        clk = 0;
  logic        rst = 1;
  logic [1:0]  mode = 2'b00;
  logic [79:0] pattern_in = '0;
  logic [7:0]  div = '0;
  logic [4:0]  row_bits;
  logic [79:0] rows_out;
  logic [3:0]  pos;
  logic        step_o, wrap_o;
  int          errors = 0, checks = 0, steps, wraps;
  panel_scroll_bank dut (
    .clk(clk), .rst(rst), .mode(mode), .pattern_in(pattern_in), .div(div),
    .row_bits(row_bits), .rows_out(rows_out), .pos(pos), .step_o(step_o), .wrap_o(wrap_o)
  );
  always #5 clk = ~clk;
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(string tag, logic [79:0] got, logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1; tick(2);
    chk("rst_rows", rows_out, '0);
    chk("rst_pos", pos, 0);
    chk("rst_step", step_o, 0);
    chk("rst_wrap", wrap_o, 0);
    rst = 0; mode = 2'b01;
    pattern_in = {16'hEE8E, 16'h0000, 16'h0000, 16'h0000, 16'hAEEE};
    tick();
    chk("load_rows", rows_out, {16'hEE8E, 48'h0, 16'hAEEE});
    chk("load_rowbits", row_bits, 5'b10001);
    chk("load_pos", pos, 0);
    chk("load_step", step_o, 0);
    mode = 2'b10; div = 0;
    tick();
    chk("l1_row0", rows_out[15:0], 16'h5DDD);
    chk("l1_row4", rows_out[79:64], 16'hDD1D);
    chk("l1_pos", pos, 1);
    chk("l1_step", step_o, 1);
    steps = 1; wraps = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      steps += int'(step_o);
      wraps += int'(wrap_o);
    end
    chk("l16_row0", rows_out[15:0], 16'hAEEE);
    chk("l16_row4", rows_out[79:64], 16'hEE8E);
    chk("l16_pos", pos, 0);
    chk("l16_wrap", wrap_o, 1);
    chk("l16_steps", steps, 16);
    chk("l16_wraps", wraps, 1);
    mode = 2'b01; pattern_in = 80'h1;
    tick();
    chk("load2_rows", rows_out, 80'h1);
    mode = 2'b11; div = 3;
    tick(3);
    chk("r_early_step", step_o, 0);
    chk("r_early_pos", pos, 0);
    tick();
    chk("r1_row0", rows_out[15:0], 16'h8000);
    chk("r1_pos", pos, 15);
    chk("r1_step", step_o, 1);
    chk("r1_wrap", wrap_o, 0);
    steps = 0; wraps = 0;
    for (int i = 0; i < 59; i++) begin
      tick();
      steps += int'(step_o);
      wraps += int'(wrap_o);
    end
    chk("r_prewraps", wraps, 0);
    tick();
    steps += int'(step_o);
    chk("r16_wrap", wrap_o, 1);
    chk("r16_steps", steps, 15);
    chk("r16_row0", rows_out[15:0], 16'h0001);
    chk("r16_pos", pos, 0);
    mode = 2'b10; div = 3;
    tick(2);
    mode = 2'b00;
    tick(5);
    chk("hold_pos", pos, 0);
    chk("hold_rows", rows_out, 80'h1);
    chk("hold_step", step_o, 0);
    mode = 2'b10;
    tick(3);
    chk("resume_nostep", step_o, 0);
    chk("resume_pos0", pos, 0);
    tick();
    chk("resume_step", step_o, 1);
    chk("resume_row0", rows_out[15:0], 16'h0002);
    chk("resume_pos", pos, 1);
    div = 0;
    tick(6);
    chk("mid_pos", pos, 7);
    chk("mid_row0", rows_out[15:0], 16'h0080);
    mode = 2'b01; pattern_in = {80{1'b1}};
    tick();
    chk("ldmid_pos", pos, 0);
    chk("ldmid_rows", rows_out, {80{1'b1}});
    chk("ldmid_step", step_o, 0);
    chk("ldmid_wrap", wrap_o, 0);
    mode = 2'b10; div = 2;
    tick();
    mode = 2'b11;
    tick();
    chk("dir_nostep", step_o, 0);
    tick();
    chk("dir_step", step_o, 1);
    chk("dir_pos", pos, 15);
    chk("dir_nowrap", wrap_o, 0);
    mode = 2'b10; div = 0;
    tick();
    chk("pre_rst_step", step_o, 1);
    rst = 1;
    tick();
    chk("rrot_rows", rows_out, '0);
    chk("rrot_pos", pos, 0);
    chk("rrot_step", step_o, 0);
    chk("rrot_wrap", wrap_o, 0);
    rst = 0; mode = 2'b01;
    tick();
    chk("reload_rows", rows_out, {80{1'b1}});
    rst = 1;
    tick();
    chk("rst_over_load", rows_out, '0);
    chk("rst_over_load_bits", row_bits, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
